// File: rtl/risc_v_mike_uart_loader_pkg.sv
// Shared types and constants for the UART boot loader.
// Optional checksum byte is enabled by defining RISC_V_MIKE_LOADER_CHECKSUM_EN.
package risc_v_mike_uart_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA,
        CHK,
        DONE,
        ERR
    } t_loader_state;

    localparam logic [7:0]  LOADER_SYNC_BYTE = 8'hA5;
    localparam int unsigned LOADER_LEN_W     = 16;

    // Little-endian assembly: the three earlier bytes sit in sr as {b2, b1, b0}.
    function automatic logic [31:0] pack_le_word(input logic [7:0] b3, input logic [23:0] sr);
        return {b3, sr};
    endfunction

endpackage

// File: rtl/risc_v_mike_uart_loader_if.sv
// Byte receive handshake and instruction memory write port of the boot loader.
// master = loader side, slave = UART / memory side.
interface risc_v_mike_uart_loader_if #(
    parameter int unsigned IMEM_ADDR_W = 8
);
    logic [7:0]             rx_data;
    logic                   rx_flag;
    logic                   rx_flag_clr;
    logic                   imem_wr_en;
    logic [IMEM_ADDR_W-1:0] imem_wr_addr;
    logic [31:0]            imem_wr_data;

    modport master (
        input  rx_data,
        input  rx_flag,
        output rx_flag_clr,
        output imem_wr_en,
        output imem_wr_addr,
        output imem_wr_data
    );

    modport slave (
        output rx_data,
        output rx_flag,
        input  rx_flag_clr,
        input  imem_wr_en,
        input  imem_wr_addr,
        input  imem_wr_data
    );
endinterface

// File: rtl/risc_v_mike_uart_loader_byte_rx.sv
// rx_flag / rx_flag_clr handshake: accepts at most one byte every two cycles
// and presents it as a one-cycle byte_valid pulse.
module risc_v_mike_uart_loader_byte_rx (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_flag,
    output logic       rx_flag_clr,
    output logic       byte_valid,
    output logic [7:0] byte_data
);
    logic clr_pending;
    logic accept;

    // The UART drops rx_flag one cycle after the ack, so the pending cycle
    // masks the stale flag and the same byte is never taken twice.
    assign accept      = rx_flag && !clr_pending;
    assign rx_flag_clr = clr_pending;
    assign byte_valid  = clr_pending;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clr_pending <= 1'b0;
            byte_data   <= '0;
        end else begin
            clr_pending <= accept;
            if (accept) begin
                byte_data <= rx_data;
            end
        end
    end
endmodule

// File: rtl/risc_v_mike_uart_loader.sv
// UART boot loader: parses SYNC / LEN_LO / LEN_HI / data words and writes
// instruction memory. Checksum byte under RISC_V_MIKE_LOADER_CHECKSUM_EN.
module risc_v_mike_uart_loader
    import risc_v_mike_uart_loader_pkg::*;
#(
    parameter int unsigned IMEM_DEPTH  = 256,
    parameter int unsigned IMEM_ADDR_W = 8,
    parameter logic [7:0]  SYNC_BYTE   = LOADER_SYNC_BYTE
) (
    input  logic                      clk,
    input  logic                      rst,
    risc_v_mike_uart_loader_if.master ldr,
    output logic                      core_rst,
    output logic                      load_done,
    output logic                      load_error
);
    localparam logic [LOADER_LEN_W-1:0] DEPTH_L = LOADER_LEN_W'(IMEM_DEPTH);

    t_loader_state             state, state_n;
    logic                      byte_valid;
    logic [7:0]                byte_data;
    logic [LOADER_LEN_W-1:0]   count;
    logic [LOADER_LEN_W-1:0]   len_n;
    logic [IMEM_ADDR_W-1:0]    word_idx;
    logic [1:0]                byte_idx;
    logic [23:0]               word_sr;
    logic                      last_word;
    logic                      wr_fire;
    logic                      stay_done;
`ifdef RISC_V_MIKE_LOADER_CHECKSUM_EN
    logic [7:0]                sum;
`endif

    risc_v_mike_uart_loader_byte_rx u_byte_rx (
        .clk         (clk),
        .rst         (rst),
        .rx_data     (ldr.rx_data),
        .rx_flag     (ldr.rx_flag),
        .rx_flag_clr (ldr.rx_flag_clr),
        .byte_valid  (byte_valid),
        .byte_data   (byte_data)
    );

    assign len_n     = {byte_data, count[7:0]};
    assign last_word = (LOADER_LEN_W'(word_idx) == count - LOADER_LEN_W'(1));
    assign stay_done = (state == DONE) && (state_n == DONE);

    always_comb begin
        state_n = state;
        wr_fire = 1'b0;
        case (state)
            IDLE: if (byte_valid && byte_data == SYNC_BYTE) state_n = LEN_LO;
            LEN_LO: if (byte_valid) state_n = LEN_HI;
            LEN_HI: begin
                if (byte_valid) begin
                    if (len_n == '0)          state_n = DONE;
                    else if (len_n > DEPTH_L) state_n = ERR;
                    else                      state_n = DATA;
                end
            end
            DATA: begin
                if (byte_valid && byte_idx == 2'd3) begin
                    wr_fire = 1'b1;
`ifdef RISC_V_MIKE_LOADER_CHECKSUM_EN
                    if (last_word) state_n = CHK;
`else
                    if (last_word) state_n = DONE;
`endif
                end
            end
`ifdef RISC_V_MIKE_LOADER_CHECKSUM_EN
            CHK: if (byte_valid) state_n = (byte_data == sum) ? DONE : ERR;
`endif
            DONE, ERR: if (byte_valid && byte_data == SYNC_BYTE) state_n = LEN_LO;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            count            <= '0;
            word_idx         <= '0;
            byte_idx         <= '0;
            word_sr          <= '0;
            ldr.imem_wr_en   <= 1'b0;
            ldr.imem_wr_addr <= '0;
            ldr.imem_wr_data <= '0;
            core_rst         <= 1'b1;
            load_done        <= 1'b0;
            load_error       <= 1'b0;
`ifdef RISC_V_MIKE_LOADER_CHECKSUM_EN
            sum              <= '0;
`endif
        end else begin
            state          <= state_n;
            ldr.imem_wr_en <= wr_fire;
            if (wr_fire) begin
                ldr.imem_wr_addr <= word_idx;
                ldr.imem_wr_data <= pack_le_word(byte_data, word_sr);
            end
            // Release lags DONE entry by one cycle; a reload SYNC re-asserts at once.
            core_rst   <= !stay_done;
            load_done  <= stay_done;
            load_error <= (state_n == ERR);

            if (byte_valid) begin
                case (state)
                    LEN_LO: count[7:0] <= byte_data;
                    LEN_HI: begin
                        count[15:8] <= byte_data;
                        word_idx    <= '0;
                        byte_idx    <= '0;
`ifdef RISC_V_MIKE_LOADER_CHECKSUM_EN
                        sum         <= '0;
`endif
                    end
                    DATA: begin
                        word_sr  <= {byte_data, word_sr[23:8]};
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3 && !last_word) begin
                            word_idx <= word_idx + 1'b1;
                        end
`ifdef RISC_V_MIKE_LOADER_CHECKSUM_EN
                        sum <= sum + byte_data;
`endif
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule
